// File: rtl/otter_muldiv_pkg.sv
// otter_muldiv_pkg -- shared constants and enums for the RV32M multiply/divide unit.
//   WIDTH     : operand/result width (only 32 is supported)
//   LAST_ITER : final value of the 5-bit iteration counter in CALC
//   op_t      : RV32M funct3 encodings
//   state_t   : sequencer states
package otter_muldiv_pkg;

  localparam int WIDTH = 32;
  localparam logic [4:0] LAST_ITER = 5'd31;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_sign_unit.sv
// muldiv_sign_unit -- combinational operand conditioning for otter_muldiv.
//   op             : RV32M funct3
//   src_a, src_b   : raw operands
//   mag_a, mag_b   : operand magnitudes (signed operands are absolute-valued)
//   negate         : final result must be two's-complement negated
//   special        : divide-by-zero or signed-overflow case, no iteration needed
//   special_result : result to report for the special case
module muldiv_sign_unit #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             negate,
  output logic             special,
  output logic [WIDTH-1:0] special_result
);
  import otter_muldiv_pkg::*;

  op_t  op_e;
  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;
  logic div_zero;
  logic div_ovf;

  always_comb begin
    op_e     = op_t'(op);
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_e)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase

    a_neg = a_signed & src_a[WIDTH-1];
    b_neg = b_signed & src_b[WIDTH-1];
    mag_a = a_neg ? -src_a : src_a;
    mag_b = b_neg ? -src_b : src_b;

    // Remainder follows the dividend sign; every other result uses sign XOR.
    if (op_e == OP_REM) negate = a_neg;
    else                negate = a_neg ^ b_neg;

    div_zero = op[2] && (src_b == '0);
    div_ovf  = ((op_e == OP_DIV) || (op_e == OP_REM)) &&
               (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);
    special  = div_zero | div_ovf;

    // op[1] selects the remainder flavours among the divide ops.
    special_result = '0;
    if (div_zero)     special_result = op[1] ? src_a : '1;
    else if (div_ovf) special_result = op[1] ? '0 : src_a;
  end

endmodule

// File: rtl/otter_muldiv.sv
// otter_muldiv -- iterative RV32M multiply/divide unit (radix-2 shift-add and
// restoring division, 32 iterations; special divide cases finish immediately).
//   CLK, RST_N    : clock, asynchronous active-low reset
//   start, op     : request and funct3; srcA/srcB operands, latched in IDLE
//   flush         : abandon the operation in flight (no done, result kept)
//   busy          : high in every state except IDLE
//   done          : one-cycle pulse, result valid and updated on that cycle
//   result        : last completed result, held until the next done
//   state_dbg     : current sequencer state
// Handshake: start is accepted only when busy=0 and flush=0; it is ignored
// otherwise. Every accepted start yields exactly one done pulse unless flush
// or reset intervenes; a new start may be presented in the done cycle.
module otter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       state_dbg
);
  import otter_muldiv_pkg::*;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q;
  op_t                op_q;
  logic               neg_q;
  logic               special_q;
  logic [WIDTH-1:0]   spec_res_q;
  logic [2*WIDTH-1:0] a_q;      // multiplicand, shifts left each iteration
  logic [WIDTH-1:0]   b_q;      // multiplier (shifts right) or divisor
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   quo_q;    // dividend shifts out the top as quotient bits enter
  logic [WIDTH-1:0]   rem_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;

  logic [WIDTH-1:0]   sp_mag_a, sp_mag_b, sp_special_result;
  logic               sp_negate, sp_special;

  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_final;

  muldiv_sign_unit #(.WIDTH(WIDTH)) u_sign (
    .op             (op),
    .src_a          (srcA),
    .src_b          (srcB),
    .mag_a          (sp_mag_a),
    .mag_b          (sp_mag_b),
    .negate         (sp_negate),
    .special        (sp_special),
    .special_result (sp_special_result)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !flush) state_d = sp_special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (flush)                   state_d = ST_IDLE;
        else if (cnt_q == LAST_ITER) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One iteration of each datapath.
  always_comb begin
    // The restored remainder is always below the divisor, so 32 bits hold it;
    // only the shifted partial remainder needs the extra bit.
    partial  = {rem_q, quo_q[WIDTH-1]};
    diff     = partial - {1'b0, b_q};
    rem_nxt  = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    prod_nxt = b_q[0] ? (prod_q + a_q) : prod_q;
  end

  // Sign fix-up and result selection for the DONE cycle.
  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -quo_q  : quo_q;
    rem_fix  = neg_q ? -rem_q  : rem_q;
    case (op_q)
      OP_MUL:                        res_final = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  res_final = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               res_final = quo_fix;
      default:                       res_final = rem_fix;
    endcase
    if (special_q) res_final = spec_res_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (start && !flush) begin
            op_q       <= op_t'(op);
            neg_q      <= sp_negate;
            special_q  <= sp_special;
            spec_res_q <= sp_special_result;
            a_q        <= {{WIDTH{1'b0}}, sp_mag_a};
            b_q        <= sp_mag_b;
            prod_q     <= '0;
            quo_q      <= sp_mag_a;
            rem_q      <= '0;
          end
        end
        ST_CALC: begin
          if (flush) begin
            cnt_q <= '0;
          end else begin
            // Wraps from LAST_ITER back to 0 as the FSM leaves CALC.
            cnt_q <= cnt_q + 5'd1;
            if (op_q[2]) begin
              rem_q <= rem_nxt;
              quo_q <= quo_nxt;
            end else begin
              prod_q <= prod_nxt;
              a_q    <= a_q << 1;
              b_q    <= b_q >> 1;
            end
          end
        end
        ST_DONE: begin
          cnt_q <= '0;
          if (!flush) begin
            done_q   <= 1'b1;
            result_q <= res_final;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_otter_muldiv.sv
// tb_otter_muldiv -- self-checking bench for otter_muldiv: directed RV32M
// vectors, randomized operations against an arithmetic reference model,
// start-while-busy noise, flush in each state, and reset mid-operation.
module tb_otter_muldiv;

  // ---------------- clock / reset / DUT ----------------
  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] srcA  = '0;
  logic [31:0] srcB  = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  always #5 CLK = ~CLK;

  otter_muldiv #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .op        (op),
    .srcA      (srcA),
    .srcB      (srcB),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    bit          noisy;
  } vec_t;

  vec_t dir_v[15] = '{
    '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1},
    '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0},
    '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, 1'b1},
    '{3'b100, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 33, 1'b0},
    '{3'b110, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 33, 1'b1},
    '{3'b101, 32'd100,       32'd7,         32'd14,        33, 1'b0},
    '{3'b111, 32'd100,       32'd7,         32'd2,         33, 1'b0},
    '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0},
    '{3'b111, 32'd5,         32'd0,         32'd5,         1,  1'b1},
    '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0},
    '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  1'b0},
    '{3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, 1'b0},
    '{3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         33, 1'b0},
    '{3'b100, 32'd0,         32'd0,         32'hFFFF_FFFF, 1,  1'b0},
    '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 33, 1'b1}
  };

  // Reference model: plain 64-bit arithmetic plus the RV32M corner rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (f3)
      3'b000: begin p = ua * ub;           r = p[31:0];  end
      3'b001: begin p = sa * sb;           r = p[63:32]; end
      3'b010: begin p = sa * longint'(ub); r = p[63:32]; end
      3'b011: begin p = ua * ub;           r = p[63:32]; end
      3'b100: begin
        if (b == 0)                                     r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'b101: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      3'b110: begin
        if (b == 0)                                     r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    bit sp;
    sp = f3[2] && ((b == 0) ||
         (((f3 == 3'b100) || (f3 == 3'b110)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return sp ? 1 : 33;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one operation, optionally throwing random start pulses at the busy
  // unit, then check latency, result, busy profile and the done pulse width.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input bit noisy, input string tag);
    int          n;
    bit          seen;
    bit          busy_ok;
    logic [31:0] want;
    exp_q.push_back(exp);
    op = f3; srcA = a; srcB = b; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "/busy_after_accept"}, busy, 1);
    n = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < 40) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        op    = 3'($urandom);
        srcA  = $urandom;
        srcB  = $urandom;
      end
      tick();
      n++;
      seen = done;
      if (!seen && busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    want  = exp_q.pop_front();
    chk({tag, "/latency"}, n, lat);
    chk({tag, "/result"}, result, want);
    chk({tag, "/busy_at_done"}, busy, 0);
    chk({tag, "/busy_while_running"}, busy_ok, 1);
    last_result = want;
    tick();
    chk({tag, "/done_one_cycle"}, done, 0);
    chk({tag, "/result_held"}, result, want);
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    bit quiet;
    quiet = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk({tag, "/no_done_after"}, quiet, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    // Reset state.
    #1;
    chk("reset/busy", busy, 0);
    chk("reset/done", done, 0);
    chk("reset/result", result, 0);
    chk("reset/state", state_dbg, 0);
    tick();
    tick();
    RST_N = 1'b1;

    // First start right after release; basic MUL latency and busy profile.
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0, "mul_7x-3");

    foreach (dir_v[i])
      run_op(dir_v[i].f3, dir_v[i].a, dir_v[i].b, dir_v[i].exp,
             dir_v[i].lat, dir_v[i].noisy, $sformatf("dir%0d", i));

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      rf3 = 3'($urandom);
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(rf3, ra, rb, ref_model(rf3, ra, rb), ref_latency(rf3, ra, rb),
             1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0d", i, rf3));
    end

    // Flush at cycle 10 of a MUL.
    op = 3'b000; srcA = 32'd3; srcB = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_calc/busy", busy, 0);
    chk("flush_calc/done", done, 0);
    chk("flush_calc/result", result, last_result);
    expect_quiet(40, "flush_calc");

    // Flush in the DONE state of a special-case divide.
    op = 3'b101; srcA = 32'd9; srcB = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("flush_done/busy_in_done", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_done/done", done, 0);
    chk("flush_done/busy", busy, 0);
    chk("flush_done/result", result, last_result);

    // Flush together with start in IDLE: start is dropped.
    op = 3'b000; srcA = 32'd2; srcB = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start/busy", busy, 0);
    expect_quiet(5, "flush_start");

    // Flush alone in IDLE, then a normal operation still works.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle/busy", busy, 0);
    run_op(3'b101, 32'd1000, 32'd9, 32'd111, 33, 1'b0, "after_flush_idle");

    // Reset at cycle 20 of a divide.
    op = 3'b100; srcA = 32'hFFFF_F000; srcB = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    RST_N = 1'b0;
    #1;
    chk("mid_reset/busy", busy, 0);
    chk("mid_reset/done", done, 0);
    chk("mid_reset/result", result, 0);
    chk("mid_reset/state", state_dbg, 0);
    tick();
    tick();
    RST_N = 1'b1;
    last_result = '0;
    expect_quiet(40, "mid_reset");

    // Start on the very first edge after a release.
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0, "first_after_reset");

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
